instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_pkg.sv | 9 +
 rtl/instr_fetch_ctrl_fetch_fifo.sv | 49 ++++
 rtl/instr_fetch_ctrl.sv | 81 ++++++++
 tb/tb_instr_fetch_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared fetch FSM encoding and instruction size.
package instr_fetch_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// fetch_fifo: two-entry FIFO with flush; push accepted when full if a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequential instruction fetcher with redirect, range halt and a two-entry output buffer.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int                    bus_length = 64,
    parameter logic [bus_length-1:0] RESET_PC   = '0,
    parameter int                    MEM_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic [bus_length-1:0] mem_addr,
    input  logic [31:0]           mem_instr,
    input  logic                  redirect_valid,
    input  logic [bus_length-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [bus_length-1:0] out_pc,
    output logic                  halted,
    output logic [31:0]           instr_count
);
    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [bus_length-1:0] fetch_pc;
    logic [bus_length:0]   fetch_end;
    logic                  in_range;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // one extra bit so the end address cannot wrap near the top of the address space
    assign fetch_end = {1'b0, fetch_pc} + (bus_length+1)'(INSTR_BYTES);
    assign in_range  = fetch_end <= (bus_length+1)'(MEM_BYTES);
    assign mem_addr  = fetch_pc;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == RUN) && !redirect_valid && in_range && (!fifo_full || pop);
    assign halted    = state_q == HALT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fetch_en ? RUN : IDLE;
            RUN:     state_d = !fetch_en ? IDLE : (!redirect_valid && !in_range) ? HALT : RUN;
            HALT:    state_d = redirect_valid ? RUN : HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc    <= RESET_PC;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[bus_length-1:2], 2'b00};
            else if (push)
                fetch_pc <= fetch_pc + bus_length'(INSTR_BYTES);
            if (pop)
                instr_count <= instr_count + 32'd1;
        end
    end

    fetch_fifo #(
        .WIDTH(32 + bus_length)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(redirect_valid),
        .push (push),
        .pop  (pop),
        .din  ({mem_instr, fetch_pc}),
        .dout ({out_instr, out_pc}),
        .full (fifo_full),
        .empty(fifo_empty)
    );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed checks of fetch streaming, stall, redirect, range halt, reset and counter wrap.
module tb_instr_fetch_ctrl;
    localparam int BL = 64;
    localparam int MB = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [BL-1:0] redirect_pc = '0;
    logic [BL-1:0] mem_addr;
    logic [BL-1:0] out_pc;
    logic [31:0]   mem_instr;
    logic [31:0]   out_instr;
    logic [31:0]   instr_count;
    logic          out_valid;
    logic          halted;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    assign mem_instr = (mem_addr == '0) ? 32'h0020_81B3 : (32'h1000_0000 | mem_addr[31:0]);

    instr_fetch_ctrl #(
        .bus_length(BL),
        .RESET_PC  ('0),
        .MEM_BYTES (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_halted", 64'(halted), 0);
        check("rst_count", 64'(instr_count), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", 64'(out_instr), 0);
        reset = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        step();
        check("cycle1_valid", 64'(out_valid), 0);
        step();
        check("cycle2_valid", 64'(out_valid), 1);
        check("first_instr", 64'(out_instr), 64'h0020_81B3);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            check("stream_pc", out_pc, 64'(4 * k));
            check("stream_count", 64'(instr_count), 64'(k));
        end
        out_ready = 1'b0;
        step(5);
        check("stall_pc", out_pc, 8);
        check("stall_addr", mem_addr, 16);
        check("stall_valid", 64'(out_valid), 1);
        check("stall_count", 64'(instr_count), 2);
        out_ready = 1'b1;
        for (int pc = 8; pc <= 24; pc += 4) begin
            if (pc > 8) step();
            check("drain_pc", out_pc, 64'(pc));
        end
        check("halt_set", 64'(halted), 1);
        step();
        check("halt_empty", 64'(out_valid), 0);
        check("halt_addr", mem_addr, 28);
        check("halt_count", 64'(instr_count), 7);
        step();
        check("halt_hold", 64'(out_valid), 0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        check("resume_halted", 64'(halted), 0);
        check("resume_addr", mem_addr, 0);
        check("resume_valid", 64'(out_valid), 0);
        step();
        check("resume_out_valid", 64'(out_valid), 1);
        check("resume_pc", out_pc, 0);
        out_ready = 1'b0;
        step(2);
        check("full_pc", out_pc, 0);
        check("full_addr", mem_addr, 8);
        redirect_valid = 1'b1;
        redirect_pc = 64'h13;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("redir_flush", 64'(out_valid), 0);
        check("redir_addr", mem_addr, 64'h10);
        check("redir_count", 64'(instr_count), 8);
        step();
        check("redir_valid", 64'(out_valid), 1);
        check("redir_pc", out_pc, 64'h10);
        check("redir_instr", 64'(out_instr), 64'h1000_0010);
        out_ready = 1'b0;
        step();
        check("hold_pc", out_pc, 64'h10);
        check("hold_addr", mem_addr, 64'h18);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        out_ready = 1'b1;
        step();
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_count", 64'(instr_count), 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_pc", out_pc, 0);
        check("mid_rst_halted", 64'(halted), 0);
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        step(3);
        check("refill_pc", out_pc, 0);
        check("refill_addr", mem_addr, 8);
        fetch_en = 1'b0;
        out_ready = 1'b1;
        step();
        check("idle_pc4", out_pc, 4);
        step();
        check("idle_pc8", out_pc, 8);
        check("idle_addr", mem_addr, 12);
        step();
        check("idle_empty", 64'(out_valid), 0);
        check("idle_addr_frozen", mem_addr, 12);
        check("idle_count", 64'(instr_count), 3);
        out_ready = 1'b0;
        force dut.instr_count = 32'hFFFF_FFFF;
        step();
        release dut.instr_count;
        step();
        check("preload_count", 64'(instr_count), 64'hFFFF_FFFF);
        fetch_en = 1'b1;
        step(2);
        check("wrap_head", out_pc, 12);
        out_ready = 1'b1;
        step();
        check("wrap_count", 64'(instr_count), 0);
        check("wrap_next_pc", out_pc, 16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
